arch_state_loader: RTL and testbench
====================================

# arch_state_loader

Restores architectural state into the core from an external snapshot (difftest checkpoint or golden-model resync). Accepts one full snapshot (PC, 32 GPRs, mstatus/mtvec/mepc/mcause) over a valid/ready handshake, stalls the core, and replays it as a sequence of register-file writes, then CSR writes, then a PC redirect. It sits beside the register file and CSR unit and feeds their write ports through the core's existing write muxes.

## Interface
- `XLEN`, 32: data width of PC, GPRs, CSRs.
- `NREGS`, 32: GPR count; `regs_flat` holds reg i at `[i*XLEN +: XLEN]`.

- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `load_valid`  in  1  snapshot available.
- `load_ready`  out  1  loader idle, can accept.
- `pc`  in  XLEN  snapshot PC.
- `regs_flat`  in  NREGS*XLEN  snapshot GPRs.
- `mtvec`, `mepc`, `mstatus`, `mcause`  in  XLEN each  snapshot CSRs.
- `wr_ready`  in  1  write ports may take a write this cycle.
- `rf_wen`  out  1  GPR write strobe.
- `rf_waddr`  out  5  GPR index.
- `rf_wdata`  out  XLEN  GPR data.
- `csr_wen`  out  1  CSR write strobe.
- `csr_waddr`  out  12  CSR address.
- `csr_wdata`  out  XLEN  CSR data.
- `redirect_valid`  out  1  one-cycle PC redirect.
- `redirect_pc`  out  XLEN  redirect target.
- `core_stall`  out  1  hold core fetch/commit.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, GPR, CSR, REDIRECT.
- IDLE: `load_ready`=1; on `load_valid && load_ready`, latch all snapshot inputs into internal registers, set index=1, go GPR. Inputs are not sampled again until next accept.
- GPR: drive `rf_wen`=1, `rf_waddr`=index, `rf_wdata`=latched reg[index]. x0 is never written. Write completes when `wr_ready`=1; then index+1. After index 31 completes -> CSR (or REDIRECT without CSR feature).
- CSR: four writes in fixed order: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342; each completes on `wr_ready`=1. After the fourth -> REDIRECT.
- REDIRECT: `redirect_valid`=1, `redirect_pc`=latched PC, `done`=1 for exactly one cycle, not gated by `wr_ready`; next state IDLE.
- `core_stall`=1 in every state except IDLE.
- `wr_ready`=0: hold strobe, address, data stable; no index advance.
- `load_valid` while busy: ignored (`load_ready`=0), no effect on current load.
- Strobes are zero whenever not in the owning state; `rf_wen` and `csr_wen` are never high together.

## Timing
- Reset (async assert, any time incl. mid-load): state IDLE, index 0; `load_ready`=1, all strobes, `redirect_valid`, `done`, `core_stall`=0, all address/data outputs 0. Partial load is abandoned; no resume.
- Accept at edge T, `wr_ready` held 1: `rf_wen` cycles T+1..T+31 (addr 1..31); `csr_wen` T+32..T+35; `redirect_valid`/`done` T+36; `load_ready`=1 at T+37. Total 36 busy cycles.
- Each `wr_ready`=0 cycle during GPR/CSR adds one cycle.
- Outputs are registered or decoded from registered state only; no combinational path from `load_valid` or snapshot inputs to outputs.
- Back-to-back: a new `load_valid` at T+37 is accepted that cycle.

## Configuration
- `ARCH_STATE_LOADER_CSR_EN` defined: CSR state present, four CSR writes as above, 36 busy cycles.
- Undefined: CSR state and `csr_*` logic removed (`csr_wen`, `csr_waddr`, `csr_wdata` tied 0); CSR inputs unused; GPR -> REDIRECT directly; `redirect_valid`/`done` at T+32, 32 busy cycles.

## Test plan
- Snapshot reg[i]=0x1000_0000+i, pc=0x8000_0100, mtvec=0x8000_0400, mepc=0x8000_0200, mstatus=0x1800, mcause=0xB, `wr_ready`=1 -> 31 writes addr 1..31 data 0x1000_0001..0x1000_001F, CSR writes 0x300/0x1800, 0x305/0x8000_0400, 0x341/0x8000_0200, 0x342/0xB, redirect to 0x8000_0100 with `done` at T+36.
- reg[0]=0xDEAD_BEEF -> no write with `rf_waddr`=0 ever issued.
- `wr_ready`=0 for 3 cycles at addr 7 and 2 cycles at 0x341 -> outputs held stable, redirect at T+41, no writes duplicated or skipped.
- Change snapshot inputs and pulse `load_valid` at T+10 -> ignored, written data matches values latched at T; `load_ready`=0 until T+37.
- Assert `reset` at T+15 -> all outputs 0, `load_ready`=1 same cycle; new load afterwards starts from addr 1.
- Macro undefined -> `csr_wen` never high, redirect/`done` at T+32.

Source files
------------

// File: rtl/arch_state_loader.sv
// Architectural state loader: latches a snapshot and replays it as GPR writes, optional CSR writes
// (enabled by ARCH_STATE_LOADER_CSR_EN), and then a one-cycle PC redirect with a done pulse.
module arch_state_loader #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [XLEN-1:0]       pc,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic [XLEN-1:0]       mtvec,
  input  logic [XLEN-1:0]       mepc,
  input  logic [XLEN-1:0]       mstatus,
  input  logic [XLEN-1:0]       mcause,
  input  logic                  wr_ready,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  csr_wen,
  output logic [11:0]           csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  core_stall,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, GPR, CSR, REDIRECT} state_t;

  state_t                     state, state_nxt;
  logic [4:0]                 idx;
  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [XLEN-1:0]            pc_q;
  logic                       accept, gpr_last, csr_last;
  logic [11:0]                csr_addr;
  logic [XLEN-1:0]            csr_data;

  assign accept   = (state == IDLE) && load_valid;
  assign gpr_last = (state == GPR) && wr_ready && (idx == 5'(NREGS-1));

`ifdef ARCH_STATE_LOADER_CSR_EN
  localparam bit HAS_CSR = 1'b1;

  logic [1:0]            cidx;
  logic [3:0][XLEN-1:0]  csr_q;   // [0]=mstatus [1]=mtvec [2]=mepc [3]=mcause

  assign csr_last = (state == CSR) && wr_ready && (cidx == 2'd3);
  assign csr_data = csr_q[cidx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cidx  <= '0;
      csr_q <= '0;
    end else if (accept) begin
      cidx  <= '0;
      csr_q <= {mcause, mepc, mtvec, mstatus};
    end else if ((state == CSR) && wr_ready) begin
      cidx  <= cidx + 2'd1;
    end
  end

  always_comb begin
    csr_addr = 12'h300;
    case (cidx)
      2'd0: csr_addr = 12'h300;
      2'd1: csr_addr = 12'h305;
      2'd2: csr_addr = 12'h341;
      2'd3: csr_addr = 12'h342;
      default: csr_addr = 12'h300;
    endcase
  end
`else
  localparam bit HAS_CSR = 1'b0;

  logic unused_csr;
  assign unused_csr = ^{mtvec, mepc, mstatus, mcause};
  assign csr_last   = 1'b0;
  assign csr_addr   = '0;
  assign csr_data   = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (load_valid) state_nxt = GPR;
      GPR:      if (gpr_last)   state_nxt = HAS_CSR ? CSR : REDIRECT;
      CSR:      if (csr_last)   state_nxt = REDIRECT;
      REDIRECT:                 state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // x0 is skipped by starting at 1; idx wraps back to 0 after the last GPR write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      regs_q <= '0;
      pc_q   <= '0;
    end else if (accept) begin
      idx    <= 5'd1;
      regs_q <= regs_flat;
      pc_q   <= pc;
    end else if ((state == GPR) && wr_ready) begin
      idx    <= idx + 5'd1;
    end
  end

  always_comb begin
    load_ready     = (state == IDLE);
    core_stall     = (state != IDLE);
    rf_wen         = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    done           = 1'b0;
    case (state)
      GPR: begin
        rf_wen   = 1'b1;
        rf_waddr = idx;
        rf_wdata = regs_q[idx];
      end
      CSR: begin
        csr_wen   = HAS_CSR;
        csr_waddr = csr_addr;
        csr_wdata = csr_data;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
        done           = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arch_state_loader.sv
// Scoreboard bench for arch_state_loader: a snapshot model queues expected writes/redirect,
// and a negedge monitor pops and compares them along with handshake, hold and timing rules.
`timescale 1ns/1ps
module tb_arch_state_loader;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
`ifdef ARCH_STATE_LOADER_CSR_EN
  localparam bit CSR = 1'b1;
`else
  localparam bit CSR = 1'b0;
`endif
  localparam int BUSY = CSR ? 36 : 32;

  logic                  clk, reset, load_valid, load_ready, wr_ready;
  logic [XLEN-1:0]       pc, mtvec, mepc, mstatus, mcause;
  logic [NREGS*XLEN-1:0] regs_flat;
  logic                  rf_wen, csr_wen, redirect_valid, core_stall, done;
  logic [4:0]            rf_waddr;
  logic [11:0]           csr_waddr;
  logic [XLEN-1:0]       rf_wdata, csr_wdata, redirect_pc;

  arch_state_loader #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .pc(pc), .regs_flat(regs_flat), .mtvec(mtvec), .mepc(mepc), .mstatus(mstatus),
    .mcause(mcause), .wr_ready(wr_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .core_stall(core_stall),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 GPR write, 1 CSR write, 2 redirect
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0, n_fail = 0;
  int          t_acc = 0, held = 0, exp_fixed = 0;
  logic [31:0] s_regs[NREGS];
  logic [31:0] s_pc;
  logic [31:0] s_csr[4];   // mstatus, mtvec, mepc, mcause

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_model();
    exp_t e;
    for (int i = 1; i < NREGS; i++) begin
      e.kind = 0; e.addr = i; e.data = s_regs[i]; q.push_back(e);
    end
    if (CSR) begin
      e.kind = 1;
      e.addr = 'h300; e.data = s_csr[0]; q.push_back(e);
      e.addr = 'h305; e.data = s_csr[1]; q.push_back(e);
      e.addr = 'h341; e.data = s_csr[2]; q.push_back(e);
      e.addr = 'h342; e.data = s_csr[3]; q.push_back(e);
    end
    e.kind = 2; e.addr = 0; e.data = s_pc; q.push_back(e);
  endtask

  task automatic drive_inputs();
    pc = s_pc;
    for (int i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = s_regs[i];
    mstatus = s_csr[0]; mtvec = s_csr[1]; mepc = s_csr[2]; mcause = s_csr[3];
  endtask

  task automatic rand_snapshot();
    for (int i = 0; i < NREGS; i++) s_regs[i] = $urandom;
    s_pc = $urandom;
    for (int i = 0; i < 4; i++) s_csr[i] = $urandom;
  endtask

  // Monitor: all DUT sampling happens on the falling edge.
  logic        h_valid = 1'b0, prev_redir = 1'b0;
  logic [63:0] h_ctl, h_dat;
  always @(negedge clk) begin : mon
    int   rel;
    exp_t e;
    rel = cyc - t_acc + 1;
    if (reset) begin
      h_valid    = 1'b0;
      prev_redir = 1'b0;
    end else begin
      check("ready_vs_stall", {63'd0, load_ready}, {63'd0, !core_stall});
      check("wen_exclusive", {63'd0, rf_wen & csr_wen}, 64'd0);
      if (rf_wen) check("x0_write", {63'd0, rf_waddr == 5'd0}, 64'd0);
      if (h_valid) begin
        check("hold_ctl", {45'd0, rf_wen, csr_wen, rf_waddr, csr_waddr}, h_ctl);
        check("hold_data", {rf_wdata, csr_wdata}, h_dat);
        h_valid = 1'b0;
      end
      if ((rf_wen || csr_wen) && !wr_ready) begin
        held++;
        h_ctl   = {45'd0, rf_wen, csr_wen, rf_waddr, csr_waddr};
        h_dat   = {rf_wdata, csr_wdata};
        h_valid = 1'b1;
      end
      if ((rf_wen || csr_wen) && wr_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: rf_wen=%0b addr=%0d csr_wen=%0b addr=%h, none expected",
                   rf_wen, rf_waddr, csr_wen, csr_waddr);
        end else begin
          e = q.pop_front();
          check("wr_kind", csr_wen ? 64'd1 : 64'd0, 64'(e.kind));
          check("wr_addr", rf_wen ? 64'(rf_waddr) : 64'(csr_waddr), 64'(e.addr));
          check("wr_data", rf_wen ? 64'(rf_wdata) : 64'(csr_wdata), 64'(e.data));
        end
      end
      if (redirect_valid) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_redirect: pc=%h, none expected", redirect_pc);
        end else begin
          e = q.pop_front();
          check("redir_kind", 64'd2, 64'(e.kind));
          check("redir_pc", 64'(redirect_pc), 64'(e.data));
        end
        check("done_with_redir", {63'd0, done}, 64'd1);
        check("redir_cycle", 64'(rel), 64'(BUSY + held));
        if (exp_fixed != 0) check("redir_fixed_cycle", 64'(rel), 64'(exp_fixed));
      end else begin
        check("done_alone", {63'd0, done}, 64'd0);
      end
      if (prev_redir) check("ready_after_done", {63'd0, load_ready}, 64'd1);
      prev_redir = redirect_valid;
    end
  end

  // mode 0: wr_ready=1; 1: random wr_ready; 2: fixed stalls; 3: busy load_valid pulse; 4: mid-load reset
  task automatic run_load(input int mode);
    int rel, guard;
    bit fin;
    guard = 0;
    while (!load_ready && guard < 100) begin @(negedge clk); guard++; end
    check("accept_ready", {63'd0, load_ready}, 64'd1);
    exp_fixed = (mode == 0 || mode == 3) ? BUSY : (mode == 2 ? (CSR ? 41 : 35) : 0);
    drive_inputs();
    load_valid = 1'b1;
    wr_ready   = 1'b1;
    push_model();
    @(posedge clk); #1;
    load_valid = 1'b0;
    t_acc = cyc;
    held  = 0;
    fin   = 1'b0;
    for (int k = 0; k < 150 && !fin; k++) begin
      rel = cyc - t_acc + 1;
      case (mode)
        1:       wr_ready = ($urandom_range(0, 3) != 0);
        2:       wr_ready = !((rel >= 7 && rel <= 9) || (CSR && (rel == 37 || rel == 38)));
        default: wr_ready = 1'b1;
      endcase
      if (mode == 3) begin
        load_valid = (rel == 10);
        if (rel == 10) begin
          pc = ~s_pc; regs_flat = ~regs_flat;
          mstatus = ~s_csr[0]; mtvec = ~s_csr[1]; mepc = ~s_csr[2]; mcause = ~s_csr[3];
        end
      end
      if (mode == 4 && rel == 15) begin
        #2 reset = 1'b1;
        #1;
        check("rst_ready", {63'd0, load_ready}, 64'd1);
        check("rst_stall", {63'd0, core_stall}, 64'd0);
        check("rst_strobes", {60'd0, rf_wen, csr_wen, redirect_valid, done}, 64'd0);
        check("rst_addr", {47'd0, rf_waddr, csr_waddr}, 64'd0);
        check("rst_data", {rf_wdata, csr_wdata}, 64'd0);
        check("rst_pc", 64'(redirect_pc), 64'd0);
        q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        if (done) fin = 1'b1;
      end
    end
    load_valid = 1'b0;
    if (!fin) begin
      n_cmp++; n_fail++;
      $display("FAIL load_timeout: mode %0d never completed, expected done", mode);
    end
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; wr_ready = 1'b0;
    pc = '0; regs_flat = '0; mtvec = '0; mepc = '0; mstatus = '0; mcause = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("init_ready", {63'd0, load_ready}, 64'd1);
    check("init_stall", {63'd0, core_stall}, 64'd0);
    check("init_strobes", {60'd0, rf_wen, csr_wen, redirect_valid, done}, 64'd0);
    check("init_addr", {47'd0, rf_waddr, csr_waddr}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NREGS; i++) s_regs[i] = 32'h1000_0000 + i;
    s_regs[0] = 32'hDEAD_BEEF;
    s_pc = 32'h8000_0100;
    s_csr[0] = 32'h1800; s_csr[1] = 32'h8000_0400; s_csr[2] = 32'h8000_0200; s_csr[3] = 32'hB;
    run_load(0);
    run_load(2);
    rand_snapshot(); run_load(3);
    rand_snapshot(); run_load(4);
    rand_snapshot(); run_load(0);
    for (int n = 0; n < 8; n++) begin
      rand_snapshot();
      run_load(int'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    check("queue_empty", 64'(q.size()), 64'd0);
    check("final_idle", {63'd0, load_ready}, 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
